// File: rtl/r2sdf_reorder.sv
// Output reorder stage of the R2SDF FFT: turns the bit-reversed frame from the last
// butterfly stage into natural order through a ping-pong pair of 2^N-deep banks.
module r2sdf_reorder #(
    parameter int N = 3,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_ip,
    input  logic [W-1:0] ip_re,
    input  logic [W-1:0] ip_im,
    output logic [W-1:0] op_re,
    output logic [W-1:0] op_im,
    output logic         start_op,
    output logic         valid_op,
    output logic         frame_abort
);

    localparam int DEPTH = 1 << N;
    localparam logic [N-1:0] LAST = '1;
    localparam logic [N-1:0] ONE  = N'(1);

    // Write side state
    logic         wr_active_q, wr_active_d;
    logic [N-1:0] wr_cnt_q, wr_cnt_d;
    logic         wr_bank_q, wr_bank_d;

    // Read side state
    logic [N-1:0] rd_cnt_q, rd_cnt_d;
    logic         rd_bank_q, rd_bank_d;
    logic         valid_q, valid_d;
    logic         start_q, start_d;
    logic [W-1:0] op_re_q, op_re_d;
    logic [W-1:0] op_im_q, op_im_d;

    logic         wr_en;
    logic [N-1:0] wr_idx;
    logic [N-1:0] wr_addr;
    logic         handoff;
    logic         rd_en;
    logic [N-1:0] rd_idx;
    logic [N:0]   rd_addr;
    logic [2*W-1:0] rd_word;

    logic [2*W-1:0] mem [0:2*DEPTH-1];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bitrev
            assign wr_addr[gi] = wr_idx[N-1-gi];
        end
    endgenerate

    // start_ip always wins: it either opens a frame from idle or restarts the current one.
    always_comb begin
        wr_en       = start_ip | wr_active_q;
        wr_idx      = start_ip ? '0 : wr_cnt_q;
        handoff     = wr_active_q & ~start_ip & (wr_cnt_q == LAST);
        frame_abort = start_ip & wr_active_q;
        wr_bank_d   = wr_bank_q ^ handoff;
        wr_active_d = wr_active_q;
        wr_cnt_d    = wr_cnt_q;
        if (start_ip) begin
            wr_active_d = 1'b1;
            wr_cnt_d    = ONE;
        end else if (wr_active_q) begin
            if (wr_cnt_q == LAST) begin
                wr_active_d = 1'b0;
                wr_cnt_d    = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + ONE;
            end
        end
    end

    // Address 0 of the just-finished bank is fetched in the same cycle as its last write;
    // the last write goes to address 2^N-1, so the two never collide.
    always_comb begin
        rd_en     = 1'b0;
        rd_idx    = rd_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        valid_d   = 1'b0;
        start_d   = 1'b0;
        if (handoff) begin
            rd_en     = 1'b1;
            rd_idx    = '0;
            rd_cnt_d  = '0;
            rd_bank_d = wr_bank_q;
            valid_d   = 1'b1;
            start_d   = 1'b1;
        end else if (valid_q && (rd_cnt_q != LAST)) begin
            rd_en    = 1'b1;
            rd_idx   = rd_cnt_q + ONE;
            rd_cnt_d = rd_cnt_q + ONE;
            valid_d  = 1'b1;
        end
        rd_addr = {rd_bank_d, rd_idx};
        rd_word = mem[rd_addr];
        op_re_d = op_re_q;
        op_im_d = op_im_q;
        if (rd_en) begin
            op_re_d = rd_word[2*W-1:W];
            op_im_d = rd_word[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank_q, wr_addr}] <= {ip_re, ip_im};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_active_q <= 1'b0;
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            valid_q     <= 1'b0;
            start_q     <= 1'b0;
            op_re_q     <= '0;
            op_im_q     <= '0;
        end else begin
            wr_active_q <= wr_active_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            valid_q     <= valid_d;
            start_q     <= start_d;
            op_re_q     <= op_re_d;
            op_im_q     <= op_im_d;
        end
    end

    assign op_re    = op_re_q;
    assign op_im    = op_im_q;
    assign start_op = start_q;
    assign valid_op = valid_q;

endmodule

// File: tb/tb_r2sdf_reorder.sv
// Bench for r2sdf_reorder: table-driven frames with a cycle-stamped output scoreboard (N=3),
// plus hand-written reset and N=1 sequences.
module tb_r2sdf_reorder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        st3, st1;
    logic [31:0] re3, im3, re1, im1;
    logic [31:0] op_re3, op_im3, op_re1, op_im1;
    logic        sop3, vop3, fab3, sop1, vop1, fab1;

    r2sdf_reorder #(.N(3), .W(32)) dut3 (
        .clk(clk), .reset(reset), .start_ip(st3), .ip_re(re3), .ip_im(im3),
        .op_re(op_re3), .op_im(op_im3), .start_op(sop3), .valid_op(vop3),
        .frame_abort(fab3)
    );

    r2sdf_reorder #(.N(1), .W(32)) dut1 (
        .clk(clk), .reset(reset), .start_ip(st1), .ip_re(re1), .ip_im(im1),
        .op_re(op_re1), .op_im(op_im1), .start_op(sop1), .valid_op(vop1),
        .frame_abort(fab1)
    );

    typedef struct {
        int cyc;
        int re;
        bit st;
    } exp_t;

    typedef struct {
        bit st;
        int re;
        bit abort;
        bit frame;
        int base;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t tbl[$];
    bit   abort_exp [0:4095];
    int   br8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int   cyc = 0;
    int   pass_cnt = 0;
    int   chk_cnt = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    endtask

    task automatic drive(input bit st, input int re);
        @(posedge clk);
        #1;
        st3 = st;
        re3 = re;
        im3 = 32'(re * 10);
    endtask

    task automatic add_frame(input int base, input bit expect_out, input bit abort_first);
        for (int k = 0; k < 8; k++)
            tbl.push_back('{st: (k == 0), re: base + br8[k], abort: (k == 0) && abort_first,
                            frame: (k == 0) && expect_out, base: base});
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++)
            tbl.push_back('{st: 1'b0, re: (i * 37) ^ 32'h5a, abort: 1'b0, frame: 1'b0, base: 0});
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].re);
            if (tbl[i].abort) abort_exp[cyc] = 1'b1;
            if (tbl[i].frame)
                for (int j = 0; j < 8; j++)
                    exp_q.push_back('{cyc: cyc + 8 + j, re: tbl[i].base + j, st: (j == 0)});
        end
        tbl.delete();
    endtask

    // Scoreboard: every cycle either pops the expected sample due now or demands idle outputs.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                $display("cyc %0d out re=%0d im=%0d start=%0b valid=%0b",
                         cyc, op_re3, op_im3, sop3, vop3);
                chk("valid_op", {31'b0, vop3}, 32'd1);
                chk("start_op", {31'b0, sop3}, {31'b0, mon_e.st});
                chk("op_re", op_re3, mon_e.re);
                chk("op_im", op_im3, 32'(mon_e.re * 10));
            end else begin
                chk("idle_valid", {31'b0, vop3}, 32'd0);
                chk("idle_start", {31'b0, sop3}, 32'd0);
            end
            chk("frame_abort", {31'b0, fab3}, {31'b0, abort_exp[cyc]});
        end
    end

    initial begin
        reset = 1'b1;
        st3 = 1'b0; re3 = '0; im3 = '0;
        st1 = 1'b0; re1 = '0; im1 = '0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_op_re", op_re3, 0);
        chk("rst_op_im", op_im3, 0);
        chk("rst_valid", {31'b0, vop3}, 0);
        chk("rst_start", {31'b0, sop3}, 0);
        chk("rst_abort", {31'b0, fab3}, 0);
        chk("rst_valid_n1", {31'b0, vop1}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        mon_en = 1'b1;

        // Single frame, back-to-back pair, then an aborted frame restarted 3 cycles in.
        add_frame(0, 1'b1, 1'b0);
        add_idle(10);
        add_frame(0, 1'b1, 1'b0);
        add_frame(100, 1'b1, 1'b0);
        add_idle(10);
        tbl.push_back('{st: 1'b1, re: 50, abort: 1'b0, frame: 1'b0, base: 0});
        tbl.push_back('{st: 1'b0, re: 51, abort: 1'b0, frame: 1'b0, base: 0});
        tbl.push_back('{st: 1'b0, re: 52, abort: 1'b0, frame: 1'b0, base: 0});
        add_frame(200, 1'b1, 1'b1);
        add_idle(12);
        run_table();

        // Asynchronous reset in the middle of a read drops the frame.
        add_frame(0, 1'b1, 1'b0);
        add_idle(6);
        run_table();
        #1 reset = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_op_re", op_re3, 0);
        chk("arst_op_im", op_im3, 0);
        chk("arst_valid", {31'b0, vop3}, 0);
        chk("arst_start", {31'b0, sop3}, 0);
        chk("arst_abort", {31'b0, fab3}, 0);
        drive(1'b0, 0);
        drive(1'b0, 0);
        #1 reset = 1'b1;
        add_idle(12);
        add_frame(300, 1'b1, 1'b0);
        add_idle(10);
        // Idle stream with toggling data and no start_ip.
        add_idle(30);
        run_table();

        // N=1 instance: A then B, latency 2.
        @(posedge clk); #1;
        st1 = 1'b1; re1 = 32'hA5A5_0001; im1 = 32'h5A5A_0001;
        @(negedge clk);
        chk("n1_abort_s", {31'b0, fab1}, 0);
        @(posedge clk); #1;
        st1 = 1'b0; re1 = 32'hB0B0_0002; im1 = 32'h0B0B_0002;
        @(negedge clk);
        chk("n1_abort_s1", {31'b0, fab1}, 0);
        chk("n1_idle_valid", {31'b0, vop1}, 0);
        @(posedge clk); #1;
        re1 = 32'hDEAD_0003; im1 = 32'hBEEF_0003;
        @(negedge clk);
        $display("cyc %0d n1 out re=%0h im=%0h start=%0b valid=%0b", cyc, op_re1, op_im1, sop1, vop1);
        chk("n1_valid0", {31'b0, vop1}, 1);
        chk("n1_start0", {31'b0, sop1}, 1);
        chk("n1_re0", op_re1, 32'hA5A5_0001);
        chk("n1_im0", op_im1, 32'h5A5A_0001);
        @(negedge clk);
        $display("cyc %0d n1 out re=%0h im=%0h start=%0b valid=%0b", cyc, op_re1, op_im1, sop1, vop1);
        chk("n1_valid1", {31'b0, vop1}, 1);
        chk("n1_start1", {31'b0, sop1}, 0);
        chk("n1_re1", op_re1, 32'hB0B0_0002);
        chk("n1_im1", op_im1, 32'h0B0B_0002);
        @(negedge clk);
        chk("n1_valid_end", {31'b0, vop1}, 0);
        chk("n1_hold_re", op_re1, 32'hB0B0_0002);

        repeat (3) @(posedge clk);
        chk("drain", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
